// File: rtl/dma_desc_queue.sv
// Descriptor FIFO and issuer upstream of the dma engine. Buffers descriptors and issues
// them one at a time with the desc_oe/dreq/cmd/ddone handshake.
module dma_desc_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_desc,
    input  logic [1:0]    push_cmd,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic [31:0]   desc_out,
    output logic          desc_oe,
    output logic          dreq,
    output logic [1:0]    cmd,
    input  logic          ddone,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          err_timeout,
    input  logic          err_clr
);

    typedef enum logic [2:0] {StIdle, StSetup, StReq, StWait, StRecover} state_e;

    state_e          state_q;
    logic [31:0]     desc_mem_q [DEPTH];
    logic [1:0]      cmd_mem_q  [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_d;
    logic [7:0]      tmo_cnt_q;
    logic [31:0]     head_desc;
    logic [1:0]      head_cmd;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            tmo_hit;

    always_comb begin
        head_desc = desc_mem_q[rd_ptr_q];
        head_cmd  = cmd_mem_q[rd_ptr_q];
        pop       = (state_q == StIdle) && !empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        level_d   = level + (AW+1)'(push_ok) - (AW+1)'(pop);
        tmo_hit   = (state_q == StWait) && !ddone && (tmo_cnt_q == 8'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            desc_mem_q[wr_ptr_q] <= push_desc;
            cmd_mem_q[wr_ptr_q]  <= push_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            level <= level_d;
            empty <= (level_d == '0);
            full  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            desc_out    <= '0;
            desc_oe     <= 1'b0;
            dreq        <= 1'b0;
            cmd         <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;

            // A new error in the same cycle as err_clr keeps the flag set.
            if (drop)         overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (tmo_hit)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        desc_out <= head_desc;
                        if (head_desc[31:26] == 6'd0) begin
                            done <= 1'b1;
                        end else begin
                            state_q   <= StSetup;
                            busy      <= 1'b1;
                            desc_oe   <= 1'b1;
                            cmd       <= head_cmd;
                            tmo_cnt_q <= '0;
                        end
                    end
                end
                StSetup: begin
                    state_q <= StReq;
                    dreq    <= 1'b1;
                end
                StReq: begin
                    state_q <= StWait;
                    desc_oe <= 1'b0;
                end
                StWait: begin
                    if (ddone) begin
                        state_q <= StRecover;
                        dreq    <= 1'b0;
                        cmd     <= 2'b00;
                        done    <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= StRecover;
                        dreq    <= 1'b0;
                        cmd     <= 2'b00;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                StRecover: begin
                    // Wait for ddone to fall so a stale level cannot retire the next one.
                    if (!ddone) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    desc_oe <= 1'b0;
                    dreq    <= 1'b0;
                    cmd     <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Scoreboard bench for dma_desc_queue: expected issues/retirements are queued by the
// stimulus and checked by a monitor whenever desc_oe rises or done pulses.
module tb_dma_desc_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned AW      = 2;
    localparam int unsigned TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [31:0]   push_desc = '0;
    logic [1:0]    push_cmd = '0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [31:0]   desc_out;
    logic          desc_oe;
    logic          dreq;
    logic [1:0]    cmd;
    logic          ddone = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int dreq_cyc = 0;
    int oe_cyc = 0;
    int done_cyc = 0;
    logic oe_prev = 1'b0;

    logic [33:0] exp_issue [$];
    logic [31:0] exp_done  [$];

    dma_desc_queue #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_desc   (push_desc),
        .push_cmd    (push_cmd),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .desc_out    (desc_out),
        .desc_oe     (desc_oe),
        .dreq        (dreq),
        .cmd         (cmd),
        .ddone       (ddone),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_one(input logic [31:0] d, input logic [1:0] c);
        push      = 1'b1;
        push_desc = d;
        push_cmd  = c;
        tick(1);
        push      = 1'b0;
    endtask

    task automatic expect_desc(input logic [31:0] d, input logic [1:0] c,
                               input bit issued, input bit retired);
        if (issued)  exp_issue.push_back({d, c});
        if (retired) exp_done.push_back(d);
    endtask

    task automatic clear_counts();
        dreq_cyc = 0;
        oe_cyc   = 0;
        done_cyc = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_desc_oe"}, desc_oe, 0);
        check({tag, "_dreq"}, dreq, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_desc_out"}, desc_out, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_level"}, level, 0);
    endtask

    // Answer one descriptor: wait for WAIT (dreq high, desc_oe low), pulse ddone.
    task automatic complete_one(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (dreq && !desc_oe) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no WAIT phase within 300 cycles, expected one", name);
        end else begin
            ddone = 1'b1;
            tick(1);
            ddone = 1'b0;
            tick(1);
        end
    endtask

    // Monitor: compare issued/retired descriptors against the scoreboard queues.
    always @(negedge clk) begin
        logic [33:0] ei;
        logic [31:0] ed;
        if (!rst_n) begin
            oe_prev = 1'b0;
        end else begin
            if (dreq)    dreq_cyc++;
            if (desc_oe) oe_cyc++;
            if (done)    done_cyc++;
            if (desc_oe && !oe_prev) begin
                if (exp_issue.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue: got unexpected issue %0h, expected none", desc_out);
                end else begin
                    ei = exp_issue.pop_front();
                    check("issue_desc_cmd", {desc_out, cmd}, ei);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done: got unexpected done for %0h, expected none", desc_out);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_desc", desc_out, ed);
                end
            end
            if (!desc_oe && !dreq) check("cmd_idle_zero", cmd, 0);
            oe_prev = desc_oe;
        end
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        tick(1);

        // Single descriptor, ddone sampled 6 cycles after dreq rises
        clear_counts();
        expect_desc(32'h0400_4046, 2'b00, 1, 1);
        push_one(32'h0400_4046, 2'b00);
        check("t1_level_after_push", level, 1);
        check("t1_empty_after_push", empty, 0);
        tick(1);
        check("t1_oe_setup", desc_oe, 1);
        check("t1_dreq_setup", dreq, 0);
        check("t1_busy", busy, 1);
        check("t1_level_popped", level, 0);
        tick(1);
        check("t1_dreq_req", dreq, 1);
        tick(1);
        check("t1_oe_wait", desc_oe, 0);
        tick(4);
        ddone = 1'b1;
        tick(1);
        ddone = 1'b0;
        check("t1_dreq_after_ddone", dreq, 0);
        check("t1_done_pulse", done, 1);
        tick(1);
        check("t1_done_clears", done, 0);
        check("t1_busy_idle", busy, 0);
        check("t1_dreq_cycles", dreq_cyc, 6);
        check("t1_oe_cycles", oe_cyc, 2);
        check("t1_done_cycles", done_cyc, 1);
        check("t1_level_end", level, 0);

        // Fill while stalled in WAIT: four stored, fifth dropped
        expect_desc(32'h0800_2001, 2'b01, 1, 1);
        push_one(32'h0800_2001, 2'b01);
        tick(3);
        expect_desc(32'h0C00_4002, 2'b10, 1, 1);
        push_one(32'h0C00_4002, 2'b10);
        expect_desc(32'h1000_6003, 2'b11, 1, 1);
        push_one(32'h1000_6003, 2'b11);
        expect_desc(32'h1400_8004, 2'b01, 1, 1);
        push_one(32'h1400_8004, 2'b01);
        expect_desc(32'h1800_A005, 2'b10, 1, 1);
        push_one(32'h1800_A005, 2'b10);
        check("t2_full", full, 1);
        check("t2_no_overflow_yet", overflow, 0);
        push_one(32'h1C00_C006, 2'b11);
        check("t2_level_full", level, 4);
        check("t2_overflow", overflow, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t2_overflow_cleared", overflow, 0);

        // Complete the stalled one so IDLE pops exactly as a push arrives while full
        ddone = 1'b1;
        tick(1);
        ddone = 1'b0;
        tick(1);
        expect_desc(32'h2000_E007, 2'b01, 1, 1);
        push_one(32'h2000_E007, 2'b01);
        check("t3_level_stays", level, 4);
        check("t3_full_stays", full, 1);
        check("t3_no_overflow", overflow, 0);
        for (int i = 0; i < 5; i++) complete_one("t3_drain");
        tick(2);
        check("t3_empty", empty, 1);

        // Timeout: first descriptor abandoned, second then issues
        clear_counts();
        expect_desc(32'h2400_0010, 2'b10, 1, 0);
        push_one(32'h2400_0010, 2'b10);
        expect_desc(32'h2800_0020, 2'b11, 1, 1);
        push_one(32'h2800_0020, 2'b11);
        for (int i = 0; i < 400 && !err_timeout; i++) tick(1);
        check("t4_err_timeout", err_timeout, 1);
        check("t4_dreq_low", dreq, 0);
        check("t4_dreq_cycles", dreq_cyc, TIMEOUT + 1);
        check("t4_no_done", done_cyc, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_cleared", err_timeout, 0);
        complete_one("t4_next");
        check("t4_done_cycles", done_cyc, 1);

        // Count-zero descriptor retires without a bus cycle
        tick(2);
        clear_counts();
        expect_desc(32'h0000_4046, 2'b01, 0, 1);
        push_one(32'h0000_4046, 2'b01);
        tick(3);
        check("t5_oe_cycles", oe_cyc, 0);
        check("t5_dreq_cycles", dreq_cyc, 0);
        check("t5_done_cycles", done_cyc, 1);
        check("t5_busy", busy, 0);

        // Reset during WAIT with two queued
        expect_desc(32'h2C00_0030, 2'b01, 1, 0);
        push_one(32'h2C00_0030, 2'b01);
        push_one(32'h3000_0040, 2'b10);
        push_one(32'h3400_0050, 2'b11);
        tick(1);
        check("t6_in_wait", {desc_oe, dreq}, 2'b01);
        check("t6_level", level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        tick(20);
        check("t6_no_dreq", dreq_cyc, 0);
        check("t6_no_oe", oe_cyc, 0);
        check("t6_empty", empty, 1);

        check("sb_issue_left", exp_issue.size(), 0);
        check("sb_done_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
